// File: rtl/mem_ws_ctrl_pkg.sv
// Shared definitions for the wait-state memory controller: access modes,
// controller states and sizing helpers.
package mem_ws_ctrl_pkg;

  localparam int unsigned WORD_WIDTH = 16;
  localparam int unsigned CNT_BITS   = 8;

  typedef enum logic [1:0] {
    MEM_MODE_NONE    = 2'd0,
    MEM_MODE_READ    = 2'd1,
    MEM_MODE_WRITE   = 2'd2,
    MEM_MODE_ILLEGAL = 2'd3
  } mem_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Index width for the storage array; never zero so a 1-word array still has a port.
  function automatic int unsigned index_bits(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_ws_ctrl_array.sv
// WIDTH x DEPTH storage with synchronous write and registered synchronous read.
module mem_array
  import mem_ws_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_WIDTH,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = index_bits(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (re) begin
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_ws_ctrl.sv
// Single-port word memory with req/ready/ack handshake, programmable wait
// states, range checking and illegal-mode error reporting.
module mem_ws_ctrl
  import mem_ws_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH       = WORD_WIDTH,
  parameter int unsigned ADDR_BITS   = 16,
  parameter int unsigned DEPTH       = 65536,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req,
  input  logic [1:0]           mode,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [WIDTH-1:0]     wdata,
  output logic                 ready,
  output logic                 ack,
  output logic                 err,
  output logic [WIDTH-1:0]     rdata,
  output logic                 busy
);

  localparam int unsigned AW = index_bits(DEPTH);
  localparam logic [ADDR_BITS:0] DEPTH_L = (ADDR_BITS+1)'(DEPTH);

  state_e               state;
  logic [CNT_BITS-1:0]  cnt;
  mem_mode_e            mode_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [WIDTH-1:0]     wdata_q;

  logic in_range;
  logic finish;
  logic access_err;
  logic we;
  logic re;

  // Array strobes fire on the completion edge so rdata is valid during ack;
  // rst_n gating keeps an aborted write from landing.
  always_comb begin
    in_range   = ({1'b0, addr_q} < DEPTH_L);
    finish     = (state == ST_WAIT) && (cnt == '0);
    access_err = (mode_q == MEM_MODE_ILLEGAL) || (mode_q == MEM_MODE_NONE) || !in_range;
    we         = rst_n && finish && in_range && (mode_q == MEM_MODE_WRITE);
    re         = rst_n && finish && in_range && (mode_q == MEM_MODE_READ);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      ack   <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
      ready <= 1'b1;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req && (mode_q_in(mode) != MEM_MODE_NONE)) begin
            mode_q  <= mode_q_in(mode);
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt     <= CNT_BITS'(WAIT_CYCLES);
            state   <= ST_WAIT;
            ready   <= 1'b0;
            busy    <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            ack   <= 1'b1;
            err   <= access_err;
            state <= ST_IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  function automatic mem_mode_e mode_q_in(input logic [1:0] m);
    return mem_mode_e'(m);
  endfunction

  mem_array #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_array (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we),
    .re   (re),
    .addr (addr_q[AW-1:0]),
    .din  (wdata_q),
    .dout (rdata)
  );

endmodule

// File: tb/tb_mem_ws_ctrl.sv
// Directed bench for mem_ws_ctrl: three instances with 2, 0 and 4 wait states.
module tb_mem_ws_ctrl;

  localparam int W2 = 0;
  localparam int W0 = 1;
  localparam int W4 = 2;

  logic        clk = 1'b0;
  logic        rst_n [3];
  logic        req   [3];
  logic [1:0]  mode  [3];
  logic [15:0] addr  [3];
  logic [15:0] wdata [3];
  logic        ready [3];
  logic        ack   [3];
  logic        err   [3];
  logic [15:0] rdata [3];
  logic        busy  [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_ws_ctrl #(.WIDTH(16), .ADDR_BITS(16), .DEPTH(1024), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst_n(rst_n[W2]), .req(req[W2]), .mode(mode[W2]), .addr(addr[W2]),
    .wdata(wdata[W2]), .ready(ready[W2]), .ack(ack[W2]), .err(err[W2]),
    .rdata(rdata[W2]), .busy(busy[W2]));

  mem_ws_ctrl #(.WIDTH(16), .ADDR_BITS(16), .DEPTH(1024), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst_n(rst_n[W0]), .req(req[W0]), .mode(mode[W0]), .addr(addr[W0]),
    .wdata(wdata[W0]), .ready(ready[W0]), .ack(ack[W0]), .err(err[W0]),
    .rdata(rdata[W0]), .busy(busy[W0]));

  mem_ws_ctrl #(.WIDTH(16), .ADDR_BITS(16), .DEPTH(1024), .WAIT_CYCLES(4)) u_w4 (
    .clk(clk), .rst_n(rst_n[W4]), .req(req[W4]), .mode(mode[W4]), .addr(addr[W4]),
    .wdata(wdata[W4]), .ready(ready[W4]), .ack(ack[W4]), .err(err[W4]),
    .rdata(rdata[W4]), .busy(busy[W4]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One access on instance k: accept, drop req, then count edges to ack.
  task automatic xact(input int k, input logic [1:0] m, input logic [15:0] a,
                      input logic [15:0] d, input int lat, input logic exp_err);
    int n;
    check("ready_before_req", 32'(ready[k]), 32'(1));
    req[k] = 1'b1; mode[k] = m; addr[k] = a; wdata[k] = d;
    tick();
    req[k] = 1'b0; mode[k] = 2'd0;
    check("busy_after_accept", 32'(busy[k]), 32'(1));
    n = 0;
    while (n < 20) begin
      tick();
      n++;
      if (ack[k]) break;
    end
    check("ack_seen", 32'(ack[k]), 32'(1));
    check("ack_latency", 32'(n), 32'(lat));
    check("ack_err", 32'(err[k]), 32'(exp_err));
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; req[k] = 1'b0; mode[k] = 2'd0; addr[k] = '0; wdata[k] = '0;
    end
    tick();
    tick();
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    tick();

    // Reset state and ignored NONE requests
    check("rst_ready", 32'(ready[W2]), 32'(1));
    check("rst_ack", 32'(ack[W2]), 32'(0));
    check("rst_err", 32'(err[W2]), 32'(0));
    check("rst_rdata", 32'(rdata[W2]), 32'h0);
    check("rst_busy", 32'(busy[W2]), 32'(0));
    req[W2] = 1'b1; mode[W2] = 2'd0; addr[W2] = 16'h0010;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("none_no_ack", 32'(ack[W2]), 32'(0));
      check("none_ready", 32'(ready[W2]), 32'(1));
    end
    req[W2] = 1'b0;
    tick();

    // Write then read, 2 wait states
    xact(W2, 2'd2, 16'h0010, 16'hBEEF, 3, 1'b0);
    check("write_rdata_held", 32'(rdata[W2]), 32'h0);
    tick();
    check("ack_one_cycle", 32'(ack[W2]), 32'(0));
    check("err_low_without_ack", 32'(err[W2]), 32'(0));
    xact(W2, 2'd1, 16'h0010, 16'h0000, 3, 1'b0);
    check("read_beef", 32'(rdata[W2]), 32'hBEEF);
    for (int i = 0; i < 10; i++) tick();
    check("rdata_held", 32'(rdata[W2]), 32'hBEEF);

    // Zero wait, back-to-back writes with req held high
    req[W0] = 1'b1; mode[W0] = 2'd2;
    for (int i = 0; i < 4; i++) begin
      addr[W0] = 16'(i); wdata[W0] = 16'(i + 1);
      tick();
      check("b2b_accept_no_ack", 32'(ack[W0]), 32'(0));
      tick();
      check("b2b_ack", 32'(ack[W0]), 32'(1));
      check("b2b_err", 32'(err[W0]), 32'(0));
      check("b2b_ready_in_ack", 32'(ready[W0]), 32'(1));
    end
    req[W0] = 1'b0; mode[W0] = 2'd0;
    tick();
    for (int i = 0; i < 4; i++) begin
      xact(W0, 2'd1, 16'(i), 16'h0000, 1, 1'b0);
      check("b2b_readback", 32'(rdata[W0]), 32'(i + 1));
    end

    // Range and illegal-mode errors
    xact(W2, 2'd2, 16'd1024, 16'h1111, 3, 1'b1);
    xact(W2, 2'd1, 16'd1024, 16'h0000, 3, 1'b1);
    check("oor_read_rdata", 32'(rdata[W2]), 32'hBEEF);
    xact(W2, 2'd2, 16'd5, 16'h5555, 3, 1'b0);
    xact(W2, 2'd3, 16'd5, 16'hAAAA, 3, 1'b1);
    check("illegal_rdata", 32'(rdata[W2]), 32'hBEEF);
    xact(W2, 2'd1, 16'd5, 16'h0000, 3, 1'b0);
    check("illegal_no_write", 32'(rdata[W2]), 32'h5555);

    // Reset during the second WAIT cycle aborts the write
    xact(W4, 2'd2, 16'd7, 16'h0777, 5, 1'b0);
    tick();
    req[W4] = 1'b1; mode[W4] = 2'd2; addr[W4] = 16'd7; wdata[W4] = 16'h1234;
    tick();
    req[W4] = 1'b0; mode[W4] = 2'd0;
    tick();
    rst_n[W4] = 1'b0;
    tick();
    rst_n[W4] = 1'b1;
    check("abort_ready", 32'(ready[W4]), 32'(1));
    check("abort_busy", 32'(busy[W4]), 32'(0));
    for (int i = 0; i < 8; i++) begin
      tick();
      check("abort_no_ack", 32'(ack[W4]), 32'(0));
    end
    xact(W4, 2'd1, 16'd7, 16'h0000, 5, 1'b0);
    check("abort_old_value", 32'(rdata[W4]), 32'h0777);

    // Inputs changed during WAIT do not affect the transaction
    xact(W2, 2'd2, 16'd3, 16'h3333, 3, 1'b0);
    xact(W2, 2'd2, 16'd9, 16'h9999, 3, 1'b0);
    req[W2] = 1'b1; mode[W2] = 2'd1; addr[W2] = 16'd3;
    tick();
    mode[W2] = 2'd2; addr[W2] = 16'd9; wdata[W2] = 16'hDEAD;
    tick();
    tick();
    req[W2] = 1'b0; mode[W2] = 2'd0;
    tick();
    check("iso_ack", 32'(ack[W2]), 32'(1));
    check("iso_err", 32'(err[W2]), 32'(0));
    check("iso_rdata", 32'(rdata[W2]), 32'h3333);
    tick();
    xact(W2, 2'd1, 16'd9, 16'h0000, 3, 1'b0);
    check("iso_mem9", 32'(rdata[W2]), 32'h9999);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_ws_ctrl.md
Name: mem_ws_ctrl

Overview:
- Parametrised single-port word memory with a req/ready/ack handshake and a programmable number of wait states. It serves as the next-generation data/instruction store for the processor datapath.
- Replaces the old free-running, tri-stated access model with explicit request acceptance, a busy period and a one-cycle completion pulse.
- Adds range checking and illegal-mode error reporting.

Parameters:
- WIDTH, 16: data word width in bits.
- ADDR_BITS, 16: address port width.
- DEPTH, 65536: number of implemented words; must satisfy 1 <= DEPTH <= 2**ADDR_BITS.
- WAIT_CYCLES, 2: extra stall cycles per access; 0..255 allowed.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req  in  1  request valid.
- mode  in  2  access type, sampled at acceptance: MEM_MODE_NONE=0, MEM_MODE_READ=1, MEM_MODE_WRITE=2, 3 is illegal.
- addr  in  ADDR_BITS  word address, sampled at acceptance.
- wdata  in  WIDTH  write data, sampled at acceptance.
- ready  out  1  high when a request would be accepted this cycle (state IDLE).
- ack  out  1  one-cycle completion pulse.
- err  out  1  qualified by ack; 1 = access rejected.
- rdata  out  WIDTH  read result; holds its value between reads.
- busy  out  1  high while a request is in flight (state WAIT).

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state -> IDLE, cnt -> 0.
  - Outputs: ack=0, err=0, rdata=0, busy=0, ready=1 from the following cycle.
  - Array contents are not cleared.
- States: IDLE and WAIT.
- IDLE:
  - Acceptance occurs when req=1 and mode!=MEM_MODE_NONE.
  - On acceptance, latch mode/addr/wdata, load cnt=WAIT_CYCLES and go to WAIT.
  - req with MEM_MODE_NONE is ignored: no ack, stays in IDLE.
- WAIT:
  - While cnt!=0: decrement cnt; the input pins are ignored.
  - When cnt==0: perform the access, pulse ack=1 for the next cycle and return to IDLE.
- Latency: ack is high during the cycle that starts WAIT_CYCLES+1 edges after the acceptance edge.
- Throughput: at most one access per WAIT_CYCLES+2 cycles.
  - A new request may be accepted on the edge that ends the ack cycle, because ready=1 during the ack cycle.
- Read completion: rdata <= mem[addr_q], err=0.
- Write completion: mem[addr_q] <= wdata_q, err=0; rdata unchanged.
- Range violation (addr_q >= DEPTH): no array access, err=1 with ack, rdata unchanged.
- Illegal mode (3): accepted like any other request, completes with ack=1, err=1 and no access.
- err is 0 whenever ack=0.
- Read after write to the same address returns the new data.
- Reset during WAIT: the transaction is aborted, no write occurs and no ack is produced.
- Changes on req/mode/addr/wdata after acceptance have no effect on the transaction in flight.
- rdata is never tri-stated; it is always driven.

Decomposition:
- Shared definitions (signals package/include):
  - MEM_MODE_NONE/READ/WRITE/ILLEGAL constants.
  - WORD width macro.
  - State encodings ST_IDLE=0, ST_WAIT=1.
- Sub-module mem_array: synchronous-write, synchronous-read WIDTH x DEPTH storage with we/re/addr/din/dout ports.
- The controller FSM and wait counter live in mem_ws_ctrl.

Test Plan:
- Reset and idle: hold rst_n=0 for 2 cycles, then release.
  - Expect ready=1, ack=0, rdata=0.
  - req=1 with mode=0 produces no ack over 5 cycles.
- Write then read, WAIT_CYCLES=2: write 16'hBEEF to addr 16'h0010, then read addr 16'h0010.
  - Each ack arrives exactly 3 edges after acceptance, err=0.
  - rdata=16'hBEEF after the read ack and held for 10 idle cycles.
- Zero wait, WAIT_CYCLES=0, back-to-back writes: write addr 0..3 with data 1..4 (1 to addr 0, 2 to addr 1, 3 to addr 2, 4 to addr 3), holding req=1 continuously.
  - One ack every 2 cycles.
  - Reads of addr 0..3 then return 1,2,3,4 in that order.
- Errors, DEPTH=1024:
  - A write to addr 1024 gives ack=1, err=1; a following read of addr 1024 leaves rdata unchanged, err=1.
  - mode=3 at addr 5 gives ack with err=1, and mem[5] is unchanged.
- Reset mid-operation, WAIT_CYCLES=4: write 16'h1234 to addr 7, assert rst_n=0 during the 2nd WAIT cycle.
  - No ack is produced.
  - A subsequent read of addr 7 returns its pre-write value.
- Input isolation: after read acceptance at addr 3, change addr to 9 and mode to WRITE during WAIT.
  - The read returns mem[3] and mem[9] is unchanged.
